// File: rtl/imm_encoder_pkg.sv
// rtl/imm_encoder_pkg.sv - shared op codes, field positions and helpers for the immediate encoder
package imm_encoder_pkg;

    // Format selects, shared with the immediate extractor.
    typedef enum logic [2:0] {
        EXT_I = 3'b000,
        EXT_U = 3'b001,
        EXT_S = 3'b010,
        EXT_B = 3'b011,
        EXT_J = 3'b100
    } ext_op_e;

    localparam int EXT_OP_W = 3;

    // Instruction bit positions of each format's immediate fields.
    localparam int I_IMM_LSB  = 20;  // [31:20] <- imm[11:0]
    localparam int U_IMM_LSB  = 12;  // [31:12] <- imm[31:12]
    localparam int S_HI_LSB   = 25;  // [31:25] <- imm[11:5]
    localparam int S_LO_LSB   = 7;   // [11:7]  <- imm[4:0]
    localparam int B_SIGN_BIT = 31;  // [31]    <- imm[12]
    localparam int B_HI_LSB   = 25;  // [30:25] <- imm[10:5]
    localparam int B_LO_LSB   = 8;   // [11:8]  <- imm[4:1]
    localparam int B_B11_BIT  = 7;   // [7]     <- imm[11]
    localparam int J_SIGN_BIT = 31;  // [31]    <- imm[20]
    localparam int J_LO_LSB   = 21;  // [30:21] <- imm[10:1]
    localparam int J_B11_BIT  = 20;  // [20]    <- imm[11]
    localparam int J_HI_LSB   = 12;  // [19:12] <- imm[19:12]

    // True when v[31:lsb] is all zeros or all ones, i.e. v fits as a
    // sign-extended value whose sign bit sits at position lsb.
    function automatic logic is_uniform(input logic [31:0] v, input int unsigned lsb);
        logic signed [31:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/result handshake bundle for the immediate encoder
// master: request producer / result consumer; slave: the encoder.
// in_*  : request channel (in_valid/in_ready, in_imm, in_ext_op, in_base)
// out_* : result channel (out_valid/out_ready, out_inst, out_err), plus err_cnt
interface imm_encoder_if
    import imm_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ERRCNT_W   = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_imm;
    logic [EXT_OP_W-1:0]   in_ext_op;
    logic [DATA_WIDTH-1:0] in_base;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_inst;
    logic                  out_err;
    logic [ERRCNT_W-1:0]   err_cnt;

    modport master (
        output in_valid, in_imm, in_ext_op, in_base, out_ready,
        input  in_ready, out_valid, out_inst, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_imm, in_ext_op, in_base, out_ready,
        output in_ready, out_valid, out_inst, out_err, err_cnt
    );
endinterface

// File: rtl/imm_encoder_pack.sv
// rtl/imm_encoder_pack.sv - combinational immediate-to-instruction field packer
// i_imm  : immediate (byte offset for B/J)
// i_op   : format select
// i_base : instruction template, unlisted bits pass through
// o_inst : packed instruction
// o_err  : immediate not representable in the format, or op illegal
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [31:0]         i_imm,
    input  logic [EXT_OP_W-1:0] i_op,
    input  logic [31:0]         i_base,
    output logic [31:0]         o_inst,
    output logic                o_err
);

    // Fields are packed from the truncated bits even when o_err is set, so
    // a bad immediate still produces a well-formed instruction word.
    always_comb begin
        o_inst = i_base;
        o_err  = 1'b0;
        case (i_op)
            EXT_I: begin
                o_inst[I_IMM_LSB +: 12] = i_imm[11:0];
                o_err = !is_uniform(i_imm, 11);
            end
            EXT_U: begin
                o_inst[U_IMM_LSB +: 20] = i_imm[31:12];
                o_err = |i_imm[11:0];
            end
            EXT_S: begin
                o_inst[S_HI_LSB +: 7] = i_imm[11:5];
                o_inst[S_LO_LSB +: 5] = i_imm[4:0];
                o_err = !is_uniform(i_imm, 11);
            end
            EXT_B: begin
                o_inst[B_SIGN_BIT]    = i_imm[12];
                o_inst[B_HI_LSB +: 6] = i_imm[10:5];
                o_inst[B_LO_LSB +: 4] = i_imm[4:1];
                o_inst[B_B11_BIT]     = i_imm[11];
                o_err = i_imm[0] || !is_uniform(i_imm, 12);
            end
            EXT_J: begin
                o_inst[J_SIGN_BIT]     = i_imm[20];
                o_inst[J_LO_LSB +: 10] = i_imm[10:1];
                o_inst[J_B11_BIT]      = i_imm[11];
                o_inst[J_HI_LSB +: 8]  = i_imm[19:12];
                o_err = i_imm[0] || !is_uniform(i_imm, 20);
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage valid/ready immediate encoder with saturating error counter
// clk : clock
// rst : synchronous active-high reset
// bus : imm_encoder_if slave (request in, packed instruction out, err_cnt)
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ERRCNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    imm_encoder_if.slave bus
);

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_imm;
    logic [EXT_OP_W-1:0]   r_s1_op;
    logic [DATA_WIDTH-1:0] r_s1_base;

    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_out_inst;
    logic                  r_out_err;
    logic [ERRCNT_W-1:0]   r_err_cnt;

    logic                  w_s2_ready;
    logic                  w_s1_ready;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_out_fire;
    logic [DATA_WIDTH-1:0] w_inst;
    logic                  w_err;

    assign w_s2_ready = !r_s2_valid || bus.out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    // Hold off requests while reset is asserted so nothing is accepted
    // into a pipeline that is being cleared.
    assign w_in_ready = !rst && w_s1_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_fire = r_s2_valid && bus.out_ready;

    imm_pack u_pack (
        .i_imm  (r_s1_imm),
        .i_op   (r_s1_op),
        .i_base (r_s1_base),
        .o_inst (w_inst),
        .o_err  (w_err)
    );

    // Stage 1 payload needs no reset: it is qualified by r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_imm  <= bus.in_imm;
            r_s1_op   <= bus.in_ext_op;
            r_s1_base <= bus.in_base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_out_inst <= '0;
            r_out_err  <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= w_accept;
            end
            // Stage 2 only loads when it is free or draining, which keeps
            // out_inst/out_err stable during a stall.
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_inst <= w_inst;
                    r_out_err  <= w_err;
                end
            end
            if (w_out_fire && r_out_err && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_inst  = r_out_inst;
    assign bus.out_err   = r_out_err;
    assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  op;
        logic [31:0] base;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_encoder_if #(.DATA_WIDTH(32), .ERRCNT_W(16)) bus ();
    imm_encoder_if #(.DATA_WIDTH(32), .ERRCNT_W(2))  bus_s ();

    imm_encoder #(.DATA_WIDTH(32), .ERRCNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    imm_encoder #(.DATA_WIDTH(32), .ERRCNT_W(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    int checks = 0;
    int failures = 0;

    logic [32:0] q_exp[$];
    logic [31:0] q_imm[$];
    logic [2:0]  q_op[$];
    int unsigned exp_errs;
    int unsigned ops_done;
    bit          prev_stall;
    logic [32:0] prev_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Which immediate bit lands in instruction bit b for each format (-1: from base).
    function automatic int imm_src_bit(input int op, input int b);
        case (op)
            0: return (b >= 20) ? b - 20 : -1;
            1: return (b >= 12) ? b : -1;
            2: begin
                if (b >= 25) return b - 20;
                if (b >= 7 && b <= 11) return b - 7;
                return -1;
            end
            3: begin
                if (b == 31) return 12;
                if (b >= 25) return b - 20;
                if (b >= 8 && b <= 11) return b - 7;
                if (b == 7) return 11;
                return -1;
            end
            4: begin
                if (b == 31) return 20;
                if (b >= 21) return b - 20;
                if (b == 20) return 11;
                if (b >= 12) return b;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    // Reference: {err, inst}; range rules stated as signed value limits.
    function automatic logic [32:0] model(input logic [31:0] imm, input logic [2:0] op,
                                          input logic [31:0] base);
        logic [31:0] inst;
        logic        err;
        int          v;
        int          s;
        v = $signed(imm);
        inst = base;
        for (int b = 0; b < 32; b++) begin
            s = imm_src_bit(int'(op), b);
            if (s >= 0) inst[b] = imm[s];
        end
        case (op)
            3'd0, 3'd2: err = (v < -2048) || (v > 2047);
            3'd1:       err = (imm & 32'hFFF) != 0;
            3'd3:       err = ((imm & 32'h1) != 0) || (v < -4096) || (v > 4095);
            3'd4:       err = ((imm & 32'h1) != 0) || (v < -(1 << 20)) || (v > (1 << 20) - 1);
            default:    err = 1'b1;
        endcase
        return {err, inst};
    endfunction

    // Standard RISC-V immediate extraction, used for the round-trip property.
    function automatic logic [31:0] extract(input logic [31:0] i, input logic [2:0] op);
        case (op)
            3'd0: return {{20{i[31]}}, i[31:20]};
            3'd1: return {i[31:12], 12'b0};
            3'd2: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return i;
        endcase
    endfunction

    task automatic drive_req(input logic [31:0] imm, input logic [2:0] op, input logic [31:0] base);
        bus.in_imm    = imm;
        bus.in_ext_op = op;
        bus.in_base   = base;
        bus.in_valid  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus_s.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called #1 after a negedge: scores the handshakes that fire at the next posedge.
    task automatic sample_cycle();
        logic [32:0] e;
        logic [31:0] im;
        logic [2:0]  op;
        if (prev_stall)
            chk("stall_hold", {bus.out_valid, bus.out_err, bus.out_inst}, {1'b1, prev_out});
        if (bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", q_exp.size() != 0, 1);
            if (q_exp.size() != 0) begin
                e  = q_exp.pop_front();
                im = q_imm.pop_front();
                op = q_op.pop_front();
                chk("rand_out", {bus.out_err, bus.out_inst}, e);
                if (!e[32]) chk("round_trip", extract(bus.out_inst, op), im);
            end
            if (bus.out_err) exp_errs++;
            ops_done++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = {bus.out_err, bus.out_inst};
        if (bus.in_valid && bus.in_ready) begin
            q_exp.push_back(model(bus.in_imm, bus.in_ext_op, bus.in_base));
            q_imm.push_back(bus.in_imm);
            q_op.push_back(bus.in_ext_op);
        end
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 8191) - 4096;
            2: v = $urandom_range(0, (1 << 21) - 1) - (1 << 20);
            default: v = $urandom & 32'hFFFFF000;
        endcase
        if ($urandom_range(0, 1) == 1) v = v & ~32'h1;
        return v;
    endfunction

    initial begin
        vec_t        tbl[10];
        vec_t        bp[4];
        int          n;
        int          k;
        int          got;
        int          first_cyc;
        int          last_cyc;
        int unsigned exp_cnt;
        logic [32:0] held;
        logic [32:0] e;

        tbl[0] = '{32'hFFFFF800, 3'd0, 32'h00000013, 32'h80000013, 1'b0};
        tbl[1] = '{32'h00000800, 3'd0, 32'h00000013, 32'h80000013, 1'b1};
        tbl[2] = '{32'hFFFFFFFE, 3'd3, 32'h00000063, 32'hFE000FE3, 1'b0};
        tbl[3] = '{32'h00000003, 3'd3, 32'h00000063, 32'h00000163, 1'b1};
        tbl[4] = '{32'h00000800, 3'd4, 32'h0000006F, 32'h0010006F, 1'b0};
        tbl[5] = '{32'h12345000, 3'd1, 32'h00000537, 32'h12345537, 1'b0};
        tbl[6] = '{32'h12345001, 3'd1, 32'h00000537, 32'h12345537, 1'b1};
        tbl[7] = '{32'h12345001, 3'd7, 32'h00000537, 32'h00000537, 1'b1};
        tbl[8] = '{32'hFFFFFFFF, 3'd2, 32'h00002023, 32'hFE002FA3, 1'b0};
        tbl[9] = '{32'h00100000, 3'd4, 32'h0000006F, 32'h8000006F, 1'b1};

        bp[0] = '{32'h00000001, 3'd0, 32'h00000013, 32'h0, 1'b0};
        bp[1] = '{32'h00000002, 3'd0, 32'h00000093, 32'h0, 1'b0};
        bp[2] = '{32'hFFFFFFFC, 3'd2, 32'h00002023, 32'h0, 1'b0};
        bp[3] = '{32'h00ABC000, 3'd1, 32'h00000537, 32'h0, 1'b0};

        bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_ext_op = '0; bus.in_base = '0;
        bus.out_ready = 1'b1;
        bus_s.in_valid = 1'b0; bus_s.in_imm = '0; bus_s.in_ext_op = 3'd7; bus_s.in_base = '0;
        bus_s.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_inst", bus.out_inst, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Directed table, one request at a time
        exp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_req(tbl[i].imm, tbl[i].op, tbl[i].base);
            bus.out_ready = 1'b1;
            #1;
            chk("tbl_in_ready", bus.in_ready, 1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (i == 0) chk("lat_early", bus.out_valid, 0);
            n = 0;
            while (!bus.out_valid && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (i == 0) chk("lat_cycles", n, 1);
            chk("tbl_valid", bus.out_valid, 1);
            chk("tbl_inst", bus.out_inst, tbl[i].exp_inst);
            chk("tbl_err", bus.out_err, tbl[i].exp_err);
            chk("tbl_model", model(tbl[i].imm, tbl[i].op, tbl[i].base),
                {tbl[i].exp_err, tbl[i].exp_inst});
            exp_cnt += tbl[i].exp_err;
            @(negedge clk);
            #1;
            chk("tbl_err_cnt", bus.err_cnt, exp_cnt);
        end

        // Backpressure: only two requests fit while the output is stalled
        q_exp.delete(); q_imm.delete(); q_op.delete();
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_req(bp[k].imm, bp[k].op, bp[k].base);
            #1;
            if (bus.in_ready) begin
                q_exp.push_back(model(bp[k].imm, bp[k].op, bp[k].base));
                k++;
            end
        end
        chk("bp_accepted", k, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        held = {bus.out_err, bus.out_inst};
        repeat (3) @(negedge clk);
        #1;
        chk("bp_stable", {bus.out_valid, bus.out_err, bus.out_inst}, {1'b1, held});
        got = 0; first_cyc = -1; last_cyc = -1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (k < 4) drive_req(bp[k].imm, bp[k].op, bp[k].base);
            else bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                e = (q_exp.size() != 0) ? q_exp.pop_front() : 33'h0;
                chk("bp_order", {bus.out_err, bus.out_inst}, e);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q_exp.push_back(model(bp[k].imm, bp[k].op, bp[k].base));
                k++;
            end
        end
        bus.in_valid = 1'b0;
        chk("bp_drained", got, 4);
        chk("bp_one_per_cycle", last_cyc - first_cyc, 3);

        // Reset mid-stream with both stages full and err_cnt=5
        do_reset();
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_req(32'h0, 3'd7, 32'h1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_err_cnt5", bus.err_cnt, 5);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_req(32'h4 * i, 3'd0, 32'h13);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("mid_full_valid", bus.out_valid, 1);
        chk("mid_full_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("mid_post_in_ready", bus.in_ready, 1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) n++;
        end
        chk("mid_no_emit", n, 0);

        // Saturation on the narrow-counter instance: five errors into a 2-bit counter
        @(negedge clk);
        bus_s.in_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus_s.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("sat_err_cnt", bus_s.err_cnt, 3);

        // Randomized traffic against the scoreboard
        do_reset();
        q_exp.delete(); q_imm.delete(); q_op.delete();
        exp_errs = 0; ops_done = 0; prev_stall = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 40000 && ops_done < 10000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) < 9)
                drive_req(rand_imm(), 3'($urandom_range(0, 4)), $urandom);
            else
                drive_req(rand_imm(), 3'($urandom_range(5, 7)), $urandom);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            sample_cycle();
        end
        for (int cyc = 0; cyc < 10 && q_exp.size() != 0; cyc++) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            sample_cycle();
        end
        chk("rand_ops_done", ops_done >= 10000, 1);
        chk("rand_sb_empty", q_exp.size(), 0);
        @(negedge clk);
        #1;
        chk("rand_err_cnt", bus.err_cnt, (exp_errs > 65535) ? 65535 : exp_errs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
